// File: rtl/fetch_pkg.sv
// Shared defaults for the instruction-fetch slice: bus widths, reset PC and
// the fixed instruction size used to step the fetch address.
package fetch_pkg;
  localparam int          ADDR_WIDTH   = 32;
  localparam int          INST_WIDTH   = 32;
  localparam logic [31:0] PC_RESET     = 32'h0000_0000;
  localparam int          IF_PKT_WIDTH = ADDR_WIDTH + INST_WIDTH;
  localparam int          INST_BYTES   = 4;
endpackage

// File: rtl/fetch_prefetch_if.sv
// Fetch-stage bus: I-memory request/response, redirect, and the Decode packet
// port. master is the fetch stage, slave is the surrounding pipeline/memory.
interface fetch_prefetch_if #(
  parameter int ADDR_WIDTH = fetch_pkg::ADDR_WIDTH,
  parameter int INST_WIDTH = fetch_pkg::INST_WIDTH
);
  logic [ADDR_WIDTH-1:0]            o_iaddr;
  logic                             o_iaddr_vld;
  logic                             i_iaddr_rdy;
  logic [INST_WIDTH-1:0]            i_inst;
  logic                             i_inst_vld;
  logic                             i_redir;
  logic [ADDR_WIDTH-1:0]            i_redir_pc;
  logic                             i_stall;
  logic                             o_if_pkt_vld;
  logic [ADDR_WIDTH+INST_WIDTH-1:0] o_if_pkt_data;

  modport master (
    output o_iaddr, o_iaddr_vld, o_if_pkt_vld, o_if_pkt_data,
    input  i_iaddr_rdy, i_inst, i_inst_vld, i_redir, i_redir_pc, i_stall
  );

  modport slave (
    input  o_iaddr, o_iaddr_vld, o_if_pkt_vld, o_if_pkt_data,
    output i_iaddr_rdy, i_inst, i_inst_vld, i_redir, i_redir_pc, i_stall
  );
endinterface

// File: rtl/fetch_fifo.sv
// Registered in-order FIFO with synchronous flush; storage is cleared on reset
// so the head reads zero until the first push.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
endmodule

// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: issues sequential fetches under a credit limit,
// queues returned {pc, inst} packets and discards responses made stale by a redirect.
module fetch_prefetch #(
  parameter int                    ADDR_WIDTH      = fetch_pkg::ADDR_WIDTH,
  parameter int                    INST_WIDTH      = fetch_pkg::INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] PC_RESET        = ADDR_WIDTH'(fetch_pkg::PC_RESET),
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_prefetch_if.master  bus
);
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PKT_W  = ADDR_WIDTH + INST_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(fetch_pkg::INST_BYTES);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [OUT_W-1:0]      drop_cnt_q, drop_cnt_d;

  logic [FCNT_W-1:0]     fifo_count;
  logic                  fifo_empty, fifo_full;
  logic [PKT_W-1:0]      fifo_head;
  logic [ADDR_WIDTH-1:0] redir_tgt;
  logic [31:0]           out_ext, used_ext;
  logic                  issue_vld, issue_fire, resp_take, resp_push, pkt_pop;

  // Credits cover both in-flight requests and queued packets, so a push can never overflow.
  assign out_ext    = 32'(outstanding_q);
  assign used_ext   = out_ext + 32'(fifo_count);
  assign issue_vld  = rst_n && (out_ext < 32'(MAX_OUTSTANDING)) &&
                      (used_ext < 32'(FIFO_DEPTH)) && !bus.i_redir;
  assign issue_fire = issue_vld && bus.i_iaddr_rdy;

  assign resp_take  = bus.i_inst_vld && (outstanding_q != '0);
  assign resp_push  = resp_take && (drop_cnt_q == '0) && !bus.i_redir && !fifo_full;
  assign pkt_pop    = !fifo_empty && !bus.i_stall && !bus.i_redir;
  assign redir_tgt  = bus.i_redir_pc & ~ADDR_WIDTH'(3);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (issue_fire) begin
      fetch_pc_d    = fetch_pc_q + PC_STEP;
      outstanding_d = outstanding_d + OUT_W'(1);
    end
    if (resp_take) begin
      outstanding_d = outstanding_d - OUT_W'(1);
      if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - OUT_W'(1);
      else if (resp_push)   resp_pc_d  = resp_pc_q + PC_STEP;
    end
    // Everything still in flight after this cycle's response belongs to the old path.
    if (bus.i_redir) begin
      fetch_pc_d = redir_tgt;
      resp_pc_d  = redir_tgt;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= PC_RESET;
      resp_pc_q     <= PC_RESET;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.i_redir),
    .push      (resp_push),
    .push_data ({resp_pc_q, bus.i_inst}),
    .pop       (pkt_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign bus.o_iaddr       = fetch_pc_q;
  assign bus.o_iaddr_vld   = issue_vld;
  assign bus.o_if_pkt_vld  = !fifo_empty;
  assign bus.o_if_pkt_data = fifo_head;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: in-order memory model with variable latency and a
// request/packet-queue reference model compared against the DUT every cycle.
module tb_fetch_prefetch;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_prefetch_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

  fetch_prefetch #(
    .ADDR_WIDTH      (AW),
    .INST_WIDTH      (IW),
    .PC_RESET        (32'h0000_0000),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [31:0] pc; logic stale; } infl_t;
  typedef struct packed { logic [31:0] addr; int due; } mreq_t;

  infl_t       m_infl[$];
  logic [63:0] m_fifo[$];
  logic [31:0] m_fetch_pc;
  mreq_t       mem_q[$];
  int          last_due;
  int          cyc;

  logic        redir_r = 1'b0;
  logic [31:0] redir_pc_r = '0;
  logic        stall_r = 1'b0;
  logic        rdy_r = 1'b1;
  logic        stray_r = 1'b0;
  int          lat_r = 1;

  logic        cur_iaddr_vld;
  logic [31:0] cur_iaddr;
  logic        cur_pkt_vld;
  logic [63:0] cur_pkt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int stale_cnt();
    int n = 0;
    foreach (m_infl[i]) if (m_infl[i].stale) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_infl.delete();
    m_fifo.delete();
    mem_q.delete();
    m_fetch_pc = 32'h0;
    last_due   = 0;
  endtask

  // One clock cycle: memory drives its response, outputs are compared, then model advances.
  task automatic step();
    logic        rv;
    logic [31:0] rd;
    logic        exp_vld;
    logic        m_pop;
    infl_t       e;
    int          due;
    rv = 1'b0;
    rd = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rv = 1'b1;
      rd = mem_q[0].addr ^ 32'hA5A5_A5A5;
      void'(mem_q.pop_front());
    end else if (stray_r && mem_q.size() == 0) begin
      rv = 1'b1;
      rd = $urandom;
    end
    bus.i_inst_vld  = rv;
    bus.i_inst      = rd;
    bus.i_redir     = redir_r;
    bus.i_redir_pc  = redir_pc_r;
    bus.i_stall     = stall_r;
    bus.i_iaddr_rdy = rdy_r;
    #1;
    exp_vld = (m_infl.size() < MAXO) && (m_infl.size() + m_fifo.size() < DEPTH) && !redir_r;
    chk("iaddr_vld", bus.o_iaddr_vld, exp_vld);
    chk("iaddr", bus.o_iaddr, m_fetch_pc);
    chk("pkt_vld", bus.o_if_pkt_vld, m_fifo.size() > 0);
    if (m_fifo.size() > 0) chk("pkt_data", bus.o_if_pkt_data, m_fifo[0]);
    cur_iaddr_vld = bus.o_iaddr_vld;
    cur_iaddr     = bus.o_iaddr;
    cur_pkt_vld   = bus.o_if_pkt_vld;
    cur_pkt       = bus.o_if_pkt_data;
    if (bus.o_iaddr_vld && rdy_r) begin
      due = cyc + lat_r;
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back('{addr: bus.o_iaddr, due: due});
      last_due = due;
    end
    m_pop = (m_fifo.size() > 0) && !stall_r && !redir_r;
    if (m_pop) void'(m_fifo.pop_front());
    if (rv && m_infl.size() > 0) begin
      e = m_infl.pop_front();
      if (!e.stale && !redir_r) m_fifo.push_back({e.pc, rd});
    end
    if (exp_vld && rdy_r) begin
      m_infl.push_back('{pc: m_fetch_pc, stale: 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (redir_r) begin
      m_fifo.delete();
      foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      m_fetch_pc = {redir_pc_r[31:2], 2'b00};
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n           = 1'b0;
    redir_r         = 1'b0;
    stall_r         = 1'b0;
    stray_r         = 1'b0;
    bus.i_inst_vld  = 1'b0;
    bus.i_inst      = '0;
    bus.i_redir     = 1'b0;
    bus.i_redir_pc  = '0;
    bus.i_stall     = 1'b0;
    bus.i_iaddr_rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_iaddr_vld", bus.o_iaddr_vld, 1'b0);
    chk("rst_iaddr", bus.o_iaddr, 32'h0);
    chk("rst_pkt_vld", bus.o_if_pkt_vld, 1'b0);
    chk("rst_pkt_data", bus.o_if_pkt_data, 64'h0);
    rst_n = 1'b1;
    cyc   = 1;
    rdy_r = 1'b1;
    lat_r = 1;
  endtask

  task automatic first_pkt_pc(input string name, input logic [31:0] exp_pc);
    bit found = 0;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      if (cur_pkt_vld) begin
        found = 1;
        chk(name, cur_pkt[63:32], exp_pc);
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: no packet within 30 cycles, expected pc %h", name, exp_pc);
    end
  endtask

  task automatic random_steps(input int n);
    for (int i = 0; i < n; i++) begin
      rdy_r      = ($urandom_range(0, 3) != 0);
      stall_r    = ($urandom_range(0, 3) == 0);
      lat_r      = $urandom_range(1, 4);
      redir_r    = ($urandom_range(0, 19) == 0);
      redir_pc_r = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
      step();
    end
    redir_r = 1'b0;
    stall_r = 1'b0;
  endtask

  initial begin
    // Zero-wait streaming, then a 10-cycle stall with head pc 0x8.
    apply_reset();
    step();
    chk("s1_first_req_vld", cur_iaddr_vld, 1'b1);
    chk("s1_first_req_addr", cur_iaddr, 32'h0);
    step();
    chk("s1_no_pkt_c2", cur_pkt_vld, 1'b0);
    step();
    chk("s1_pkt_c3_vld", cur_pkt_vld, 1'b1);
    chk("s1_pkt_c3", cur_pkt, 64'h0000_0000_A5A5_A5A5);
    step();
    chk("s1_pkt_c4", cur_pkt, 64'h0000_0004_A5A5_A5A1);
    stall_r = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("s2_hold_pkt", cur_pkt, 64'h0000_0008_A5A5_A5AD);
    end
    chk("s2_credit_stop", cur_iaddr_vld, 1'b0);
    stall_r = 1'b0;
    step();
    chk("s2_release_pc8", cur_pkt, 64'h0000_0008_A5A5_A5AD);
    step();
    chk("s2_release_pcC", cur_pkt, 64'h0000_000C_A5A5_A5A9);
    repeat (10) step();

    // Redirect with two requests outstanding on a 2-cycle memory.
    apply_reset();
    lat_r = 2;
    for (int n = 0; n < 10 && m_infl.size() != 2; n++) step();
    redir_r    = 1'b1;
    redir_pc_r = 32'h100;
    step();
    redir_r = 1'b0;
    chk("s3_drop_cnt", dut.drop_cnt_q, 64'd1);
    step();
    chk("s3_pkt_gap", cur_pkt_vld, 1'b0);
    chk("s3_target_req", cur_iaddr, 32'h100);
    first_pkt_pc("s3_first_target", 32'h100);
    repeat (10) step();

    // Redirect coinciding with a response and a pop.
    apply_reset();
    repeat (5) step();
    redir_r    = 1'b1;
    redir_pc_r = 32'h200;
    step();
    redir_r = 1'b0;
    chk("s4_flushed", bus.o_if_pkt_vld, 1'b0);
    chk("s4_drop_cnt", dut.drop_cnt_q, 64'(stale_cnt()));
    first_pkt_pc("s4_first_target", 32'h200);

    // Memory not ready, then an unaligned redirect target.
    apply_reset();
    rdy_r = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s5_hold_addr", cur_iaddr, 32'h0);
    end
    rdy_r = 1'b1;
    first_pkt_pc("s5_no_skip", 32'h0);
    repeat (3) step();
    redir_r    = 1'b1;
    redir_pc_r = 32'h103;
    step();
    redir_r = 1'b0;
    step();
    chk("s5_aligned_target", cur_iaddr, 32'h100);

    // Stray response with nothing outstanding, then randomized traffic.
    apply_reset();
    rdy_r   = 1'b0;
    stray_r = 1'b1;
    step();
    stray_r = 1'b0;
    step();
    chk("s6_stray_ignored", cur_pkt_vld, 1'b0);
    rdy_r = 1'b1;
    random_steps(1500);

    // Asynchronous reset asserted away from the clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_iaddr_vld", bus.o_iaddr_vld, 1'b0);
    chk("async_iaddr", bus.o_iaddr, 32'h0);
    chk("async_pkt_vld", bus.o_if_pkt_vld, 1'b0);
    chk("async_pkt_data", bus.o_if_pkt_data, 64'h0);
    apply_reset();
    step();
    chk("restart_vld", cur_iaddr_vld, 1'b1);
    chk("restart_addr", cur_iaddr, 32'h0);
    random_steps(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
